// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control path.
// Opcodes, ALUOp, PC-source and FSM state definitions.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_LUI   = 3'b011;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       halted;
  } ctrl_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_LUI, OP_LW,
      OP_SW, OP_BEQ, OP_J: return 1'b1;
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/perf_counters.sv
// Free-running cycle and retired-instruction counters.
// Both wrap silently at 2^CNT_W.
module perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             cyc_en_i,
  input  logic             ret_en_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_o <= '0;
      instr_cnt_o <= '0;
    end else begin
      if (cyc_en_i)
        cycle_cnt_o <= cycle_cnt_o + CNT_W'(1);
      if (ret_en_i)
        instr_cnt_o <= instr_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: sequences FETCH/DECODE/
// EXEC/MEM/WB over a shared memory port with a ready handshake.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  input  logic             zero_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             iord_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic [1:0]       pc_src_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_o,
  output logic [2:0]       alu_op_o,
  output logic             halted_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  localparam int WAIT_W =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
  localparam logic TO_EN = (MEM_TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [5:0]        op_q;
  logic [WAIT_W-1:0] wait_q;
  ctrl_t             c;
  logic is_r, is_addi, is_lui, is_lw, is_sw, is_beq, is_j;
  logic mem_wait, timeout, retire, cyc_en;

  assign is_r    = (op_q == OP_RTYPE);
  assign is_addi = (op_q == OP_ADDI);
  assign is_lui  = (op_q == OP_LUI);
  assign is_lw   = (op_q == OP_LW);
  assign is_sw   = (op_q == OP_SW);
  assign is_beq  = (op_q == OP_BEQ);
  assign is_j    = (op_q == OP_J);

  assign mem_wait = (state_q == S_FETCH) ||
                    (state_q == S_MEM);
  // ready cycle never times out; counter only runs while stalled
  assign timeout = TO_EN && mem_wait && !mem_ready_i &&
                   (wait_q == WAIT_LAST);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE)
        op_q <= instr_op_i;
      if (TO_EN && mem_wait && !mem_ready_i)
        wait_q <= wait_q + WAIT_W'(1);
      else
        wait_q <= '0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready_i)  state_d = S_DECODE;
        else if (timeout) state_d = S_HALT;
      end
      S_DECODE: state_d = op_legal(instr_op_i) ?
                          S_EXEC : S_HALT;
      S_EXEC: begin
        unique case (1'b1)
          is_lw, is_sw:  state_d = S_MEM;
          is_beq, is_j:  state_d = S_FETCH;
          default:       state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready_i)  state_d = is_sw ? S_FETCH : S_WB;
        else if (timeout) state_d = S_HALT;
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  always_comb begin
    c = '0;
    unique case (state_q)
      S_FETCH: begin
        c.mem_req  = 1'b1;
        c.ir_write = mem_ready_i;
        c.pc_write = mem_ready_i;
        c.pc_src   = PC_SEQ;
      end
      S_EXEC: begin
        unique case (1'b1)
          is_r:    c.alu_op = ALU_RTYPE;
          is_addi: begin
            c.alu_op  = ALU_ADD;
            c.alu_src = 1'b1;
          end
          is_lui: begin
            c.alu_op  = ALU_LUI;
            c.alu_src = 1'b1;
          end
          is_lw, is_sw: begin
            c.alu_op  = ALU_ADD;
            c.alu_src = 1'b1;
          end
          is_beq: begin
            c.alu_op   = ALU_SUB;
            c.pc_src   = PC_BR;
            c.pc_write = zero_i;
          end
          is_j: begin
            c.pc_src   = PC_JMP;
            c.pc_write = 1'b1;
          end
          default: c = '0;
        endcase
      end
      S_MEM: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
        c.mem_we  = is_sw;
      end
      S_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = is_r;
        c.mem_to_reg = is_lw;
      end
      S_HALT:  c.halted = 1'b1;
      default: c = '0;
    endcase
  end

  assign retire =
    ((state_q == S_EXEC) && (is_beq || is_j)) ||
    ((state_q == S_MEM) && is_sw && mem_ready_i) ||
    (state_q == S_WB);
  assign cyc_en = (state_q != S_RESET) &&
                  (state_q != S_HALT);

  perf_counters #(.CNT_W(CNT_W)) u_cnt (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .cyc_en_i    (cyc_en),
    .ret_en_i    (retire),
    .cycle_cnt_o (cycle_cnt_o),
    .instr_cnt_o (instr_cnt_o)
  );

  assign mem_req_o    = c.mem_req;
  assign mem_we_o     = c.mem_we;
  assign iord_o       = c.iord;
  assign ir_write_o   = c.ir_write;
  assign pc_write_o   = c.pc_write;
  assign pc_src_o     = c.pc_src;
  assign reg_write_o  = c.reg_write;
  assign reg_dst_o    = c.reg_dst;
  assign mem_to_reg_o = c.mem_to_reg;
  assign alu_src_o    = c.alu_src;
  assign alu_op_o     = c.alu_op;
  assign halted_o     = c.halted;
  assign state_o      = state_q;

endmodule
